// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in flight and
// buffers fetched words in a small circular queue that feeds decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  localparam int unsigned PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem [QDEPTH];
  logic [31:0]   pc_mem    [QDEPTH];

  logic          not_empty;
  logic          pop;
  logic          push;
  logic [CW-1:0] count_after_pop;
  logic          room;
  logic          room_after_push;
  logic [31:0]   fetch_pc_inc;

  assign not_empty       = (count_q != '0);
  assign id_valid        = not_empty & ~redirect;
  assign pop             = id_valid & id_ready;
  assign count_after_pop = count_q - CW'(pop);
  // A new request reserves a slot; after a push the next request needs one more free slot.
  assign room            = 32'(count_after_pop) < QDEPTH;
  assign room_after_push = (32'(count_after_pop) + 32'd1) < QDEPTH;
  assign fetch_pc_inc    = fetch_pc_q + 32'd4;

  assign imem_req  = (state_q != StIdle);
  assign imem_addr = addr_q;
  assign instr     = not_empty ? instr_mem[rd_ptr_q] : Nop;
  assign pc        = not_empty ? pc_mem[rd_ptr_q] : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!redirect && room) begin
          state_d = StWait;
          addr_d  = fetch_pc_q;
        end
      end
      StWait: begin
        if (imem_ack) begin
          if (redirect) begin
            state_d = StIdle;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_inc;
            if (room_after_push) begin
              addr_d = fetch_pc_inc;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (redirect) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        // The stale response still has to drain before a new request may issue.
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_after_pop + CW'(push);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a configurable-latency memory responder plus cycle-by-cycle
// checks of the request port and the decode-side queue outputs.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] instr;
  logic [31:0] pc;

  int n_checks;
  int n_pass;
  int mem_wait;
  int ack_count;
  logic force_ack;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .instr      (instr),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  // Memory responder: acks once a request has been held for mem_wait cycles.
  initial begin
    int age;
    age       = 0;
    ack_count = 0;
    imem_ack  = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        age      = age + 1;
        imem_ack = (age >= mem_wait);
        if (imem_ack) begin
          age       = 0;
          ack_count = ack_count + 1;
        end
      end else begin
        age      = 0;
        imem_ack = force_ack;
      end
      imem_rdata = mem_word(imem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Holds reset for two cycles; returns in the first cycle with reset low (cycle 0).
  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int a0;
    n_checks    = 0;
    n_pass      = 0;
    mem_wait    = 1;
    force_ack   = 1'b0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;

    // Reset values
    next_cycle();
    next_cycle();
    check("rst req", imem_req, 0);
    check("rst addr", imem_addr, 32'h0);
    check("rst valid", id_valid, 0);
    check("rst instr", instr, Nop);
    check("rst pc", pc, 32'h0);

    // 1: zero-wait memory, decode always ready
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      check("t1 req", imem_req, 1);
      check("t1 addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 2) begin
        check("t1 valid", id_valid, 1);
        check("t1 pc", pc, 32'(4 * (k - 2)));
        check("t1 instr", instr, mem_word(32'(4 * (k - 2))));
      end else begin
        check("t1 valid0", id_valid, 0);
      end
    end

    // 2: ack in the 4th cycle of each request
    mem_wait = 4;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      logic ev;
      next_cycle();
      ev = (k >= 5) && (((k - 1) % 4) == 0);
      check("t2 req", imem_req, 1);
      check("t2 addr", imem_addr, 32'(4 * ((k - 1) / 4)));
      check("t2 valid", id_valid, 32'(ev));
      if (ev) check("t2 pc", pc, 32'(4 * ((k - 1) / 4 - 1)));
    end

    // 3: decode stalled, queue fills, then drains and fetch resumes
    mem_wait = 1;
    id_ready = 1'b0;
    do_reset();
    a0 = ack_count;
    next_cycle();
    check("t3 addr0", imem_addr, 32'h0);
    next_cycle();
    check("t3 addr4", imem_addr, 32'h4);
    for (int k = 3; k <= 5; k++) begin
      next_cycle();
      check("t3 req idle", imem_req, 0);
      check("t3 hold pc", pc, 32'h0);
      check("t3 hold valid", id_valid, 1);
    end
    check("t3 acks", 32'(ack_count - a0), 32'd2);
    check("t3 instr0", instr, mem_word(32'h0));
    id_ready = 1'b1;
    next_cycle();
    check("t3 drain pc4", pc, 32'h4);
    check("t3 resume req", imem_req, 1);
    check("t3 resume addr", imem_addr, 32'h8);
    next_cycle();
    check("t3 pc8", pc, 32'h8);
    check("t3 valid8", id_valid, 1);

    // 4: redirect while the 0x8 request is outstanding
    mem_wait = 1;
    id_ready = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    mem_wait = 3;
    next_cycle();
    check("t4 addr8", imem_addr, 32'h8);
    check("t4 pre pc", pc, 32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1002;
    #1;
    check("t4 valid redirect", id_valid, 0);
    next_cycle();
    redirect = 1'b0;
    #1;
    check("t4 discard req", imem_req, 1);
    check("t4 discard addr", imem_addr, 32'h8);
    check("t4 discard valid", id_valid, 0);
    next_cycle();
    check("t4 ack req", imem_req, 1);
    check("t4 ack valid", id_valid, 0);
    next_cycle();
    check("t4 idle req", imem_req, 0);
    check("t4 idle valid", id_valid, 0);
    mem_wait = 1;
    next_cycle();
    check("t4 new addr", imem_addr, 32'h0000_1000);
    check("t4 new req", imem_req, 1);
    check("t4 new valid", id_valid, 0);
    next_cycle();
    check("t4 first valid", id_valid, 1);
    check("t4 first pc", pc, 32'h0000_1000);
    check("t4 first instr", instr, mem_word(32'h0000_1000));

    // 5: redirect in the same cycle as an ack that would fill the queue
    mem_wait = 1;
    id_ready = 1'b0;
    do_reset();
    next_cycle();
    next_cycle();
    check("t5 pre valid", id_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    #1;
    check("t5 valid redirect", id_valid, 0);
    next_cycle();
    redirect = 1'b0;
    #1;
    check("t5 empty valid", id_valid, 0);
    check("t5 empty req", imem_req, 0);
    check("t5 empty instr", instr, Nop);
    check("t5 empty pc", pc, 32'h0);
    next_cycle();
    check("t5 new addr", imem_addr, 32'h0000_2000);
    next_cycle();
    check("t5 first pc", pc, 32'h0000_2000);
    check("t5 first instr", instr, mem_word(32'h0000_2000));

    // 6: one-cycle reset during WAIT, with a stray ack arriving in IDLE afterwards
    mem_wait = 4;
    id_ready = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    check("t6 pre req", imem_req, 1);
    reset     = 1'b1;
    force_ack = 1'b1;
    next_cycle();
    check("t6 rst req", imem_req, 0);
    check("t6 rst valid", id_valid, 0);
    check("t6 rst addr", imem_addr, 32'h0);
    reset     = 1'b0;
    force_ack = 1'b0;
    mem_wait  = 1;
    next_cycle();
    check("t6 restart req", imem_req, 1);
    check("t6 restart addr", imem_addr, 32'h0);
    check("t6 stray ignored", id_valid, 0);
    next_cycle();
    check("t6 pc0", pc, 32'h0);
    check("t6 valid0", id_valid, 1);
    next_cycle();
    check("t6 pc4", pc, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
